// File: rtl/spi_regbank_pkg.sv
// Shared types and constants for the spi_regbank SPI mode-0 register target.
package spi_regbank_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        DATA = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_e;

    localparam logic SPI_WRITE_BIT = 1'b1;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_regbank_sync_edge.sv
// Two-flop synchroniser plus history flop; edges come from the last two synchronised samples.
module spi_sync_edge #(
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;
    logic       hist_q;
    logic       hist_d;

    // Next values of the synchroniser chain and history flop
    always_comb begin
        sync_d = {sync_q[0], d};
        hist_d = sync_q[1];
    end

    // Synchroniser and history registers, reset to the line's idle level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{IDLE_VAL}};
            hist_q <= IDLE_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~hist_q;
    assign fall  = ~sync_q[1] & hist_q;

endmodule

// File: rtl/spi_regbank.sv
// SPI mode-0 register bank with read-back, frame-length checking and write strobes.
// Optional abort counter output enabled by SPI_REGBANK_ABORT_CNT_EN.
module spi_regbank
    import spi_regbank_pkg::*;
#(
    parameter int                NUM_REGS  = 5,
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 7,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       nCS,
    input  logic                       SCLK,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        wr_stb
`ifdef SPI_REGBANK_ABORT_CNT_EN
    ,
    output logic [7:0]                 abort_cnt
`endif
);

    localparam int FRAME   = frame_len(ADDR_W, DATA_W);
    localparam int CMD_LEN = 1 + ADDR_W;
    localparam int CNT_W   = $clog2(FRAME + 1);
    localparam int SH_W    = (CMD_LEN > DATA_W) ? CMD_LEN : DATA_W;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0] CMD_CNT   = CNT_W'(CMD_LEN);

    logic ncs_lvl_s, ncs_rise_s, ncs_fall_s;
    logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
    logic copi_lvl_s, copi_rise_s, copi_fall_s;
    logic sync_unused_s;

    spi_sync_edge #(.IDLE_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d(nCS),
        .level(ncs_lvl_s), .rise(ncs_rise_s), .fall(ncs_fall_s)
    );
    spi_sync_edge #(.IDLE_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(SCLK),
        .level(sclk_lvl_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    spi_sync_edge #(.IDLE_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d(COPI),
        .level(copi_lvl_s), .rise(copi_rise_s), .fall(copi_fall_s)
    );

    assign sync_unused_s = &{sclk_lvl_s, copi_rise_s, copi_fall_s};

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SH_W-1:0]       shift_q, shift_d;
    logic                  rw_q, rw_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     out_shift_q, out_shift_d;
    logic                  cipo_q, cipo_d;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_stb_q, wr_stb_d;
    logic [DATA_W-1:0]     rd_val_s;
    logic                  sclk_rise_act_s, sclk_fall_act_s;
    logic                  commit_s, enter_data_s, rd_phase_s;

    // SCLK edges only count while chip select is low
    assign sclk_rise_act_s = sclk_rise_s & ~ncs_lvl_s;
    assign sclk_fall_act_s = sclk_fall_s & ~ncs_lvl_s;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            out_shift_q <= '0;
            cipo_q      <= 1'b0;
            wr_stb_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            out_shift_q <= out_shift_d;
            cipo_q      <= cipo_d;
            wr_stb_q    <= wr_stb_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Next-state logic; a chip-select release always wins
    always_comb begin
        state_d = state_q;
        if (ncs_rise_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (ncs_fall_s) state_d = CMD; else state_d = IDLE;
                CMD: begin
                    if (sclk_rise_act_s && (cnt_q == CMD_CNT - 1'b1)) state_d = DATA;
                    else state_d = CMD;
                end
                DATA: begin
                    if (sclk_rise_act_s && (cnt_q == FRAME_CNT - 1'b1)) state_d = DONE;
                    else state_d = DATA;
                end
                DONE: if (sclk_rise_act_s) state_d = ERR; else state_d = DONE;
                ERR:  state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and output logic: bit capture, read shifter, commit
    always_comb begin
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        out_shift_d = out_shift_q;
        rd_val_s    = '0;

        if ((state_q == IDLE) && ncs_fall_s) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (sclk_rise_act_s && ((state_q == CMD) || (state_q == DATA))) begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = {shift_q[SH_W-2:0], copi_lvl_s};
        end else begin
            cnt_d   = cnt_q;
            shift_d = shift_q;
        end

        enter_data_s = (state_q == CMD) && (state_d == DATA);
        rd_phase_s   = ((state_q == DATA) || (state_q == DONE)) && (rw_q != SPI_WRITE_BIT);

        if (enter_data_s) begin
            rw_d   = shift_d[ADDR_W];
            addr_d = shift_d[ADDR_W-1:0];
            for (int i = 0; i < NUM_REGS; i++) begin
                if (int'(addr_d) == i) rd_val_s = regs_q[i];
                else rd_val_s = rd_val_s;
            end
            if (rw_d != SPI_WRITE_BIT) out_shift_d = rd_val_s;
            else out_shift_d = out_shift_q;
        end else if (sclk_fall_act_s && rd_phase_s && (cnt_q != CMD_CNT)) begin
            // The fall right after the last address bit keeps the MSB on the line
            out_shift_d = {out_shift_q[DATA_W-2:0], 1'b0};
        end else begin
            out_shift_d = out_shift_q;
        end

        if (((state_d == DATA) || (state_d == DONE)) && (rw_d != SPI_WRITE_BIT)) begin
            cipo_d = out_shift_d[DATA_W-1];
        end else begin
            cipo_d = 1'b0;
        end

        commit_s = ncs_rise_s && (state_q == DONE) && (rw_q == SPI_WRITE_BIT) && (cnt_q == FRAME_CNT);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit_s && (int'(addr_q) == i)) begin
                regs_d[i]   = shift_q[DATA_W-1:0];
                wr_stb_d[i] = 1'b1;
            end else begin
                regs_d[i]   = regs_q[i];
                wr_stb_d[i] = 1'b0;
            end
        end
    end

`ifdef SPI_REGBANK_ABORT_CNT_EN
    logic [7:0] abort_cnt_q, abort_cnt_d;
    logic       abort_s;

    // Saturating count of short and overlong frames
    always_comb begin
        abort_s = ncs_rise_s && ((state_q == CMD) || (state_q == DATA) || (state_q == ERR));
        if (abort_s && (abort_cnt_q != 8'hFF)) abort_cnt_d = abort_cnt_q + 8'd1;
        else abort_cnt_d = abort_cnt_q;
    end

    // Abort counter register, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) abort_cnt_q <= 8'd0;
        else abort_cnt_q <= abort_cnt_d;
    end

    assign abort_cnt = abort_cnt_q;
`else
    localparam logic ABORT_CNT_EN = 1'b0;
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign wr_stb = wr_stb_q;
    assign CIPO   = cipo_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Self-checking bench for spi_regbank: directed cases then randomized frames against a register model.
module tb_spi_regbank;

    localparam int NUM_REGS = 5;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 7;
    localparam int HALF     = 80;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ncs = 1'b1;
    logic sclk = 1'b0;
    logic copi = 1'b0;
    logic cipo;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [NUM_REGS-1:0] wr_stb;
`ifdef SPI_REGBANK_ABORT_CNT_EN
    logic [7:0] abort_cnt;
`endif

    spi_regbank #(
        .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_VAL(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .nCS(ncs), .SCLK(sclk), .COPI(copi), .CIPO(cipo),
        .regs_flat(regs_flat), .wr_stb(wr_stb)
`ifdef SPI_REGBANK_ABORT_CNT_EN
        , .abort_cnt(abort_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int stb_cnt = 0;
    int exp_stb = 0;
    int exp_abort = 0;
    logic [NUM_REGS-1:0] stb_last = '0;
    logic [DATA_W-1:0] model [NUM_REGS];

    always @(negedge clk) begin
        if (wr_stb !== '0) begin
            stb_cnt++;
            stb_last = wr_stb;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
        logic [NUM_REGS*DATA_W-1:0] f;
        for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = model[i];
        return f;
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a);
        if (int'(a) < NUM_REGS) return model[a];
        else return 8'h00;
    endfunction

    task automatic model_write(input logic [6:0] a, input logic [7:0] d);
        if (int'(a) < NUM_REGS) begin
            model[a] = d;
            exp_stb++;
        end
    endtask

    // Drives nbits MSB-first; collects CIPO just before each rising SCLK
    task automatic xfer(input int nbits, input logic [31:0] word, input bit release_cs,
                        output logic [31:0] miso);
        miso = '0;
        ncs = 1'b0;
        #(HALF);
        for (int k = 0; k < nbits; k++) begin
            copi = word[nbits-1-k];
            #(HALF);
            miso = {miso[30:0], cipo};
            sclk = 1'b1;
            #(HALF);
            sclk = 1'b0;
        end
        #(HALF);
        if (release_cs) ncs = 1'b1;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d, input int gap);
        logic [31:0] miso;
        xfer(16, 32'({1'b1, a, d}), 1'b1, miso);
        model_write(a, d);
        #(gap);
        check("wr_regs", 64'(regs_flat), 64'(model_flat()));
        check("wr_stb_count", 64'(stb_cnt), 64'(exp_stb));
        if (int'(a) < NUM_REGS) check("wr_stb_onehot", 64'(stb_last), 64'(5'b00001 << a));
    endtask

    task automatic do_read(input logic [6:0] a, input int gap);
        logic [31:0] miso;
        xfer(16, 32'({1'b0, a, 8'($urandom)}), 1'b1, miso);
        #(gap);
        check("rd_data", 64'(miso[7:0]), 64'(model_read(a)));
        check("rd_regs", 64'(regs_flat), 64'(model_flat()));
        check("rd_no_stb", 64'(stb_cnt), 64'(exp_stb));
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] miso;
        int waited;
        logic [6:0] ra;
        logic [7:0] rd;
        int gap;

        for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
        #(53);
        check("rst_regs", 64'(regs_flat), 64'(model_flat()));
        check("rst_stb", 64'(wr_stb), 64'(0));
        check("rst_cipo", 64'(cipo), 64'(0));
        rst_n = 1'b1;
        #(200);

        // Write A5 to reg 0; strobe and register update land on the same clk
        xfer(16, 32'({1'b1, 7'h00, 8'hA5}), 1'b1, miso);
        model_write(7'h00, 8'hA5);
        waited = 0;
        while (wr_stb === '0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("commit_latency", 64'(waited <= 5), 64'(1));
        check("commit_stb", 64'(wr_stb), 64'(5'b00001));
        check("commit_regs", 64'(regs_flat), 64'(model_flat()));
        @(negedge clk);
        check("stb_one_cycle", 64'(wr_stb), 64'(0));
        #(300);

        do_write(7'h01, 8'h3C, 300);
        do_read(7'h01, 300);
        check("idle_cipo", 64'(cipo), 64'(0));

        do_write(7'h10, 8'hFF, 300);
        do_read(7'h10, 300);

        // Short frame: 10 bits of a write to reg 2
        xfer(10, 32'({1'b1, 7'h02, 8'h77}) >> 6, 1'b1, miso);
        exp_abort++;
        #(300);
        check("short_regs", 64'(regs_flat), 64'(model_flat()));
        check("short_stb", 64'(stb_cnt), 64'(exp_stb));
`ifdef SPI_REGBANK_ABORT_CNT_EN
        check("short_abort_cnt", 64'(abort_cnt), 64'(exp_abort));
`endif

        // Overlong frame: 17 bits to reg 3, then a normal write
        xfer(17, 32'({1'b1, 7'h03, 8'h99, 1'b0}), 1'b1, miso);
        exp_abort++;
        #(300);
        check("long_regs", 64'(regs_flat), 64'(model_flat()));
        check("long_stb", 64'(stb_cnt), 64'(exp_stb));
`ifdef SPI_REGBANK_ABORT_CNT_EN
        check("long_abort_cnt", 64'(abort_cnt), 64'(exp_abort));
`endif
        do_write(7'h03, 8'h5A, 300);

        // SCLK/COPI activity with chip select high
        for (int k = 0; k < 20; k++) begin
            copi = 1'($urandom);
            #(HALF) sclk = 1'b1;
            #(HALF) sclk = 1'b0;
        end
        #(300);
        check("ncs_high_regs", 64'(regs_flat), 64'(model_flat()));
        check("ncs_high_stb", 64'(stb_cnt), 64'(exp_stb));

        // Reset mid-frame
        do_write(7'h02, 8'hC3, 300);
        xfer(8, 32'({1'b1, 7'h04}), 1'b0, miso);
        rst_n = 1'b0;
        #(20);
        for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
        exp_abort = 0;
        check("midrst_regs", 64'(regs_flat), 64'(model_flat()));
        check("midrst_cipo", 64'(cipo), 64'(0));
        ncs = 1'b1;
        sclk = 1'b0;
        #(200);
        rst_n = 1'b1;
        #(200);
`ifdef SPI_REGBANK_ABORT_CNT_EN
        check("midrst_abort_cnt", 64'(abort_cnt), 64'(exp_abort));
`endif
        do_write(7'h04, 8'h11, 300);

        // Randomized frames, some back-to-back with a one-SCLK-period gap
        for (int n = 0; n < 40; n++) begin
            ra = 7'($urandom_range(0, 7));
            rd = 8'($urandom);
            gap = ($urandom_range(0, 1) == 1) ? 2 * HALF : 6 * HALF;
            if ($urandom_range(0, 1) == 1) do_write(ra, rd, gap);
            else do_read(ra, gap);
        end
        #(300);
        check("final_cipo", 64'(cipo), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
